// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the IF->ID instruction fetch buffer.
package inst_fetch_buffer_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 7;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0340_0000;
    localparam logic [XLEN-1:0] PC_RESET = 32'h1c00_0000;

    // One buffered instruction: {pc, inst, taken, pc_next, exception, badv}.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  inst;
        logic             taken;
        logic [XLEN-1:0]  pc_next;
        logic [EXC_W-1:0] exception;
        logic [XLEN-1:0]  badv;
    } fb_entry_t;

    localparam int unsigned FB_ENTRY_W = $bits(fb_entry_t);

    // Field offsets inside a flattened entry (LSB positions).
    localparam int unsigned FB_BADV_LSB    = 0;
    localparam int unsigned FB_EXC_LSB     = FB_BADV_LSB + XLEN;
    localparam int unsigned FB_PC_NEXT_LSB = FB_EXC_LSB + EXC_W;
    localparam int unsigned FB_TAKEN_LSB   = FB_PC_NEXT_LSB + XLEN;
    localparam int unsigned FB_INST_LSB    = FB_TAKEN_LSB + 1;
    localparam int unsigned FB_PC_LSB      = FB_INST_LSB + XLEN;

    // Build an entry; next PC is the prediction when taken, else sequential.
    function automatic fb_entry_t make_entry(
        input logic [XLEN-1:0]  pc,
        input logic [XLEN-1:0]  inst,
        input logic             taken,
        input logic [XLEN-1:0]  pred_pc_next,
        input logic [EXC_W-1:0] exception,
        input logic [XLEN-1:0]  badv
    );
        fb_entry_t e;
        e.pc        = pc;
        e.inst      = inst;
        e.taken     = taken;
        e.pc_next   = taken ? pred_pc_next : pc + XLEN'(4);
        e.exception = exception;
        e.badv      = badv;
        return e;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Fetch buffer storage: DEPTH entries, two write ports, two async read ports.
module fb_ram
    import inst_fetch_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  we0,
    input  logic [PTR_W-1:0]      waddr0,
    input  logic [FB_ENTRY_W-1:0] wdata0,
    input  logic                  we1,
    input  logic [PTR_W-1:0]      waddr1,
    input  logic [FB_ENTRY_W-1:0] wdata1,
    input  logic [PTR_W-1:0]      raddr0,
    input  logic [PTR_W-1:0]      raddr1,
    output logic [FB_ENTRY_W-1:0] rdata0,
    output logic [FB_ENTRY_W-1:0] rdata1
);

    logic [FB_ENTRY_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Circular instruction queue between IF and ID presenting an in-order issue pair.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_readygo,
    output logic        fb_allowin,
    input  logic [1:0]  if_valid_mask,
    input  logic [31:0] if_pc0,
    input  logic [31:0] if_pc1,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    input  logic [1:0]  if_pred_taken,
    input  logic [31:0] if_pred_pc_next,
    input  logic [6:0]  if_exception,
    input  logic [31:0] if_badv,
    output logic        fb_readygo,
    input  logic        id_allowin,
    output logic [31:0] fb_pc0,
    output logic [31:0] fb_pc1,
    output logic [31:0] fb_inst0,
    output logic [31:0] fb_inst1,
    output logic [31:0] fb_pc_next,
    output logic        fb_pc_taken,
    output logic [6:0]  fb_exception,
    output logic [31:0] fb_badv
);

    logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
    logic [CNT_W-1:0] count;
    fb_entry_t        in0, in1, wdata0, h0, h1;
    logic             push_en, we0, we1, dual;
    logic [1:0]       npush, npop;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Incoming packet: exception/badv attach to the first valid slot only.
    always_comb begin
        in0    = make_entry(if_pc0, if_inst0, if_pred_taken[0], if_pred_pc_next,
                            if_exception, if_badv);
        in1    = make_entry(if_pc1, if_inst1, if_pred_taken[1], if_pred_pc_next,
                            if_valid_mask[0] ? EXC_W'(0) : if_exception,
                            if_valid_mask[0] ? XLEN'(0) : if_badv);
        wdata0 = if_valid_mask[0] ? in0 : in1;
    end

    // Push control: an excepting slot0 suppresses slot1.
    always_comb begin
        push_en = if_readygo && fb_allowin && !flush;
        we0     = push_en && (|if_valid_mask);
        we1     = push_en && (&if_valid_mask) && (if_exception == EXC_W'(0));
        npush   = {1'b0, we0} + {1'b0, we1};
    end

    fb_ram u_fb_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_p1),
        .wdata1 (in1),
        .raddr0 (head),
        .raddr1 (head_p1),
        .rdata0 (h0),
        .rdata1 (h1)
    );

    // Pair formation and pop count; id_allowin only steers pointer update.
    always_comb begin
        fb_readygo = (count != CNT_W'(0));
        fb_allowin = (count <= CNT_W'(DEPTH - 2));
        dual       = (count >= CNT_W'(2)) && !h0.taken &&
                     (h0.exception == EXC_W'(0)) && (h1.exception == EXC_W'(0));
        npop       = 2'd0;
        if (id_allowin && fb_readygo) npop = dual ? 2'd2 : 2'd1;
    end

    // Head-of-queue view presented to ID; empty shows NOP/reset PC.
    always_comb begin
        fb_pc0       = PC_RESET;
        fb_pc1       = PC_RESET;
        fb_inst0     = INST_NOP;
        fb_inst1     = INST_NOP;
        fb_pc_next   = XLEN'(0);
        fb_pc_taken  = 1'b0;
        fb_exception = EXC_W'(0);
        fb_badv      = XLEN'(0);
        if (fb_readygo) begin
            fb_pc0       = h0.pc;
            fb_inst0     = h0.inst;
            fb_exception = h0.exception;
            fb_badv      = h0.badv;
            fb_pc_next   = h0.pc_next;
            fb_pc_taken  = h0.taken;
            if (dual) begin
                fb_pc1      = h1.pc;
                fb_inst1    = h1.inst;
                fb_pc_next  = h1.pc_next;
                fb_pc_taken = h1.taken;
            end
        end
    end

    // Pointer and occupancy update; flush discards pushes and pops of its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(npop);
            tail  <= tail + PTR_W'(npush);
            count <= count + CNT_W'(npush) - CNT_W'(npop);
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer.
module tb_inst_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam logic [31:0] PCR = 32'h1c00_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_readygo;
    logic        fb_allowin;
    logic [1:0]  if_valid_mask;
    logic [31:0] if_pc0, if_pc1, if_inst0, if_inst1;
    logic [1:0]  if_pred_taken;
    logic [31:0] if_pred_pc_next;
    logic [6:0]  if_exception;
    logic [31:0] if_badv;
    logic        fb_readygo;
    logic        id_allowin;
    logic [31:0] fb_pc0, fb_pc1, fb_inst0, fb_inst1, fb_pc_next;
    logic        fb_pc_taken;
    logic [6:0]  fb_exception;
    logic [31:0] fb_badv;

    int errors = 0;
    int checks = 0;

    inst_fetch_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .if_readygo      (if_readygo),
        .fb_allowin      (fb_allowin),
        .if_valid_mask   (if_valid_mask),
        .if_pc0          (if_pc0),
        .if_pc1          (if_pc1),
        .if_inst0        (if_inst0),
        .if_inst1        (if_inst1),
        .if_pred_taken   (if_pred_taken),
        .if_pred_pc_next (if_pred_pc_next),
        .if_exception    (if_exception),
        .if_badv         (if_badv),
        .fb_readygo      (fb_readygo),
        .id_allowin      (id_allowin),
        .fb_pc0          (fb_pc0),
        .fb_pc1          (fb_pc1),
        .fb_inst0        (fb_inst0),
        .fb_inst1        (fb_inst1),
        .fb_pc_next      (fb_pc_next),
        .fb_pc_taken     (fb_pc_taken),
        .fb_exception    (fb_exception),
        .fb_badv         (fb_badv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_if();
        if_readygo    = 1'b0;
        if_valid_mask = 2'b00;
        if_pred_taken = 2'b00;
        if_exception  = 7'd0;
        if_badv       = 32'd0;
    endtask

    task automatic drive_pkt(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                             input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] tk,
                             input logic [31:0] pnext, input logic [6:0] exc, input logic [31:0] bv);
        if_readygo      = 1'b1;
        if_valid_mask   = mask;
        if_pc0          = pc0;
        if_pc1          = pc1;
        if_inst0        = i0;
        if_inst1        = i1;
        if_pred_taken   = tk;
        if_pred_pc_next = pnext;
        if_exception    = exc;
        if_badv         = bv;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_allowin = 1'b0;
        if_pc0 = 32'd0; if_pc1 = 32'd0; if_inst0 = 32'd0; if_inst1 = 32'd0; if_pred_pc_next = 32'd0;
        idle_if();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL reset_readygo: got %0b exp 0", fb_readygo); end
        checks++; if (fb_inst0 !== NOP) begin errors++; $display("FAIL reset_inst0: got %h exp %h", fb_inst0, NOP); end
        checks++; if (fb_inst1 !== NOP) begin errors++; $display("FAIL reset_inst1: got %h exp %h", fb_inst1, NOP); end
        checks++; if (fb_pc0 !== PCR) begin errors++; $display("FAIL reset_pc0: got %h exp %h", fb_pc0, PCR); end
        checks++; if (fb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %0b exp 1", fb_allowin); end
    endtask

    task automatic test_dual();
        id_allowin = 1'b1;
        drive_pkt(2'b11, 32'h1c00_0000, 32'h1c00_0004, 32'h11, 32'h22, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_readygo !== 1'b1) begin errors++; $display("FAIL dual_readygo: got %0b exp 1", fb_readygo); end
        checks++; if (fb_pc0 !== 32'h1c00_0000) begin errors++; $display("FAIL dual_pc0: got %h exp 1c000000", fb_pc0); end
        checks++; if (fb_pc1 !== 32'h1c00_0004) begin errors++; $display("FAIL dual_pc1: got %h exp 1c000004", fb_pc1); end
        checks++; if (fb_inst1 !== 32'h22) begin errors++; $display("FAIL dual_inst1: got %h exp 22", fb_inst1); end
        checks++; if (fb_pc_next !== 32'h1c00_0008) begin errors++; $display("FAIL dual_pc_next: got %h exp 1c000008", fb_pc_next); end
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL dual_drained: got %0b exp 0", fb_readygo); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] base;
        base = 32'h1c00_0010;
        id_allowin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (fb_allowin !== 1'b1) begin errors++; $display("FAIL full_allowin_%0d: got %0b exp 1", k, fb_allowin); end
            drive_pkt(2'b11, base + 32'(8*k), base + 32'(8*k + 4), 32'(16'h100 + 2*k), 32'(16'h101 + 2*k),
                      2'b00, 32'h0, 7'd0, 32'd0);
            tick();
        end
        // Buffer now holds 8 entries; a further packet must be refused.
        drive_pkt(2'b11, 32'h1c00_00f0, 32'h1c00_00f4, 32'hdead, 32'hbeef, 2'b00, 32'h0, 7'd0, 32'd0);
        checks++; if (fb_allowin !== 1'b0) begin errors++; $display("FAIL full_allowin_8: got %0b exp 0", fb_allowin); end
        tick();
        idle_if();
        checks++; if (fb_pc0 !== base) begin errors++; $display("FAIL full_head_pc0: got %h exp %h", fb_pc0, base); end
        checks++; if (fb_pc1 !== base + 32'd4) begin errors++; $display("FAIL full_head_pc1: got %h exp %h", fb_pc1, base + 32'd4); end
        id_allowin = 1'b1;
        tick();
        checks++; if (fb_allowin !== 1'b1) begin errors++; $display("FAIL pop_allowin: got %0b exp 1", fb_allowin); end
        checks++; if (fb_pc0 !== base + 32'd8) begin errors++; $display("FAIL pop1_pc0: got %h exp %h", fb_pc0, base + 32'd8); end
        tick();
        checks++; if (fb_pc0 !== base + 32'd16) begin errors++; $display("FAIL pop2_pc0: got %h exp %h", fb_pc0, base + 32'd16); end
        tick();
        checks++; if (fb_pc0 !== base + 32'd24) begin errors++; $display("FAIL pop3_pc0: got %h exp %h", fb_pc0, base + 32'd24); end
        checks++; if (fb_inst1 !== 32'h107) begin errors++; $display("FAIL pop3_inst1: got %h exp 107", fb_inst1); end
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL full_drained: got %0b exp 0", fb_readygo); end
    endtask

    task automatic test_taken();
        id_allowin = 1'b1;
        drive_pkt(2'b11, 32'h1c00_0040, 32'h1c00_0044, 32'ha0, 32'ha1, 2'b01, 32'h1c00_0100, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_pc0 !== 32'h1c00_0040) begin errors++; $display("FAIL taken_pc0: got %h exp 1c000040", fb_pc0); end
        checks++; if (fb_pc_taken !== 1'b1) begin errors++; $display("FAIL taken_flag: got %0b exp 1", fb_pc_taken); end
        checks++; if (fb_pc_next !== 32'h1c00_0100) begin errors++; $display("FAIL taken_pc_next: got %h exp 1c000100", fb_pc_next); end
        checks++; if (fb_inst1 !== NOP) begin errors++; $display("FAIL taken_inst1: got %h exp %h", fb_inst1, NOP); end
        checks++; if (fb_pc1 !== PCR) begin errors++; $display("FAIL taken_pc1: got %h exp %h", fb_pc1, PCR); end
        tick();
        checks++; if (fb_pc0 !== 32'h1c00_0044) begin errors++; $display("FAIL taken_next_pc0: got %h exp 1c000044", fb_pc0); end
        checks++; if (fb_inst0 !== 32'ha1) begin errors++; $display("FAIL taken_next_inst0: got %h exp a1", fb_inst0); end
        checks++; if (fb_pc_taken !== 1'b0) begin errors++; $display("FAIL taken_next_flag: got %0b exp 0", fb_pc_taken); end
        checks++; if (fb_pc_next !== 32'h1c00_0048) begin errors++; $display("FAIL taken_next_pc_next: got %h exp 1c000048", fb_pc_next); end
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL taken_drained: got %0b exp 0", fb_readygo); end
    endtask

    task automatic test_mask_exception();
        id_allowin = 1'b1;
        drive_pkt(2'b10, 32'h1c00_0ff0, 32'h1c00_0104, 32'hb0, 32'hb1, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_pc0 !== 32'h1c00_0104) begin errors++; $display("FAIL mask10_pc0: got %h exp 1c000104", fb_pc0); end
        checks++; if (fb_inst0 !== 32'hb1) begin errors++; $display("FAIL mask10_inst0: got %h exp b1", fb_inst0); end
        checks++; if (fb_inst1 !== NOP) begin errors++; $display("FAIL mask10_inst1: got %h exp %h", fb_inst1, NOP); end
        checks++; if (fb_pc_next !== 32'h1c00_0108) begin errors++; $display("FAIL mask10_pc_next: got %h exp 1c000108", fb_pc_next); end
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL mask10_single: got %0b exp 0", fb_readygo); end
        drive_pkt(2'b11, 32'h1c00_0200, 32'h1c00_0204, 32'hc0, 32'hc1, 2'b00, 32'h0, 7'h08, 32'h1c00_0200);
        tick();
        idle_if();
        checks++; if (fb_exception !== 7'h08) begin errors++; $display("FAIL exc_code: got %h exp 08", fb_exception); end
        checks++; if (fb_badv !== 32'h1c00_0200) begin errors++; $display("FAIL exc_badv: got %h exp 1c000200", fb_badv); end
        checks++; if (fb_inst1 !== NOP) begin errors++; $display("FAIL exc_inst1: got %h exp %h", fb_inst1, NOP); end
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL exc_slot1_dropped: got %0b exp 0", fb_readygo); end
        drive_pkt(2'b00, 32'h1c00_0300, 32'h1c00_0304, 32'hd0, 32'hd1, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL mask00_none: got %0b exp 0", fb_readygo); end
    endtask

    task automatic test_flush();
        id_allowin = 1'b0;
        drive_pkt(2'b11, 32'h1c00_0300, 32'h1c00_0304, 32'he0, 32'he1, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        drive_pkt(2'b11, 32'h1c00_0308, 32'h1c00_030c, 32'he2, 32'he3, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        drive_pkt(2'b01, 32'h1c00_0310, 32'h1c00_0314, 32'he4, 32'he5, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_pc0 !== 32'h1c00_0300) begin errors++; $display("FAIL flush_pre_pc0: got %h exp 1c000300", fb_pc0); end
        checks++; if (fb_allowin !== 1'b1) begin errors++; $display("FAIL flush_pre_allowin: got %0b exp 1", fb_allowin); end
        flush = 1'b1;
        id_allowin = 1'b1;
        drive_pkt(2'b11, 32'h1c00_0400, 32'h1c00_0404, 32'hf0, 32'hf1, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        flush = 1'b0;
        idle_if();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL flush_readygo: got %0b exp 0", fb_readygo); end
        checks++; if (fb_inst0 !== NOP) begin errors++; $display("FAIL flush_inst0: got %h exp %h", fb_inst0, NOP); end
        id_allowin = 1'b0;
        drive_pkt(2'b01, 32'h1c00_0500, 32'h1c00_0504, 32'h77, 32'h78, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_pc0 !== 32'h1c00_0500) begin errors++; $display("FAIL post_flush_pc0: got %h exp 1c000500", fb_pc0); end
        checks++; if (fb_inst1 !== NOP) begin errors++; $display("FAIL post_flush_inst1: got %h exp %h", fb_inst1, NOP); end
    endtask

    task automatic test_async_reset();
        id_allowin = 1'b0;
        drive_pkt(2'b11, 32'h1c00_0600, 32'h1c00_0604, 32'h61, 32'h62, 2'b00, 32'h0, 7'd0, 32'd0);
        tick();
        idle_if();
        checks++; if (fb_readygo !== 1'b1) begin errors++; $display("FAIL arst_pre_readygo: got %0b exp 1", fb_readygo); end
        #2 rst = 1'b1;
        #1;
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL arst_readygo: got %0b exp 0", fb_readygo); end
        checks++; if (fb_pc0 !== PCR) begin errors++; $display("FAIL arst_pc0: got %h exp %h", fb_pc0, PCR); end
        checks++; if (fb_allowin !== 1'b1) begin errors++; $display("FAIL arst_allowin: got %0b exp 1", fb_allowin); end
        #1 rst = 1'b0;
        tick();
        checks++; if (fb_readygo !== 1'b0) begin errors++; $display("FAIL arst_post_readygo: got %0b exp 0", fb_readygo); end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_full_wrap();
        test_taken();
        test_mask_exception();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
